// File: rtl/lsq_fifo.sv
// In-order load/store queue: dispatch allocates, the mem unit fills, the head entry is issued to the dcache.
// Define LSQ_PERF_CNT_EN to add the perf_ld_cnt / perf_st_cnt / perf_full_cyc counters.
module lsq_fifo #(
   parameter int LSQ_DEPTH = 8,
   parameter int LSQ_IDX_W = $clog2(LSQ_DEPTH),
   parameter int ROB_IDX_W = 5,
   parameter int PREG_W    = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 disp_valid,
   output logic                 disp_ready,
   output logic [LSQ_IDX_W-1:0] disp_lsq_idx,
   input  logic                 valid,
   input  logic [31:0]          addr,
   input  logic [2:0]           ld_str_type,
   input  logic [LSQ_IDX_W-1:0] lsq_idx,
   input  logic [ROB_IDX_W-1:0] rob_idx,
   input  logic [4:0]           rd,
   input  logic [PREG_W-1:0]    pd,
   input  logic [31:0]          str_val,
   input  logic                 is_str,
   input  logic [ROB_IDX_W-1:0] rob_head_idx,
   output logic [31:0]          dmem_addr,
   output logic [3:0]           dmem_rmask,
   output logic [3:0]           dmem_wmask,
   output logic [31:0]          dmem_wdata,
   input  logic [31:0]          dmem_rdata,
   input  logic                 dmem_resp,
   output logic                 deq_done,
   output logic [31:0]          deq_ld_data,
   output logic [4:0]           deq_rd,
   output logic [PREG_W-1:0]    deq_pd,
   output logic [ROB_IDX_W-1:0] deq_rob_idx
`ifdef LSQ_PERF_CNT_EN
   ,
   output logic [31:0]          perf_ld_cnt,
   output logic [31:0]          perf_st_cnt,
   output logic [31:0]          perf_full_cyc
`endif
);

   localparam int PTR_W = LSQ_IDX_W + 1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

   state_t                 state, state_nxt;
   logic [PTR_W-1:0]       head, tail;
   logic [LSQ_DEPTH-1:0]   alloc, addr_rdy;
   logic [31:0]            e_addr [LSQ_DEPTH];
   logic [2:0]             e_type [LSQ_DEPTH];
   logic [ROB_IDX_W-1:0]   e_rob  [LSQ_DEPTH];
   logic [4:0]             e_rd   [LSQ_DEPTH];
   logic [PREG_W-1:0]      e_pd   [LSQ_DEPTH];
   logic [31:0]            e_sval [LSQ_DEPTH];
   logic                   e_str  [LSQ_DEPTH];
   logic [LSQ_IDX_W-1:0]   hidx, tidx;
   logic                   full, head_rdy, do_disp, do_fill, do_cmpl;
   logic [3:0]             acc_mask;

   function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         2'b00:   byte_mask = 4'b0001 << off;
         2'b01:   byte_mask = 4'b0011 << off;
         default: byte_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [31:0] rdata, input logic [1:0] off,
                                            input logic [2:0] f3);
      logic [31:0] sh;
      sh = rdata >> {off, 3'b000};
      case (f3)
         3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
         3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
         3'b100:  load_ext = {24'd0, sh[7:0]};
         3'b101:  load_ext = {16'd0, sh[15:0]};
         default: load_ext = sh;
      endcase
   endfunction

   assign hidx         = head[LSQ_IDX_W-1:0];
   assign tidx         = tail[LSQ_IDX_W-1:0];
   assign full         = (hidx == tidx) && (head[LSQ_IDX_W] != tail[LSQ_IDX_W]);
   assign disp_ready   = !full;
   assign disp_lsq_idx = tidx;

   // A store may only touch memory once it is the oldest instruction in the ROB.
   assign head_rdy = alloc[hidx] && addr_rdy[hidx] &&
                     (!e_str[hidx] || (e_rob[hidx] == rob_head_idx));
   assign do_disp  = disp_valid && !full && !flush;
   assign do_fill  = valid && alloc[lsq_idx] && !flush;
   assign do_cmpl  = (state == WAIT) && dmem_resp && !flush;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!flush && head_rdy) state_nxt = REQ;
         REQ:     state_nxt = flush ? DRAIN : WAIT;
         WAIT:    if (dmem_resp) state_nxt = IDLE;
                  else if (flush) state_nxt = DRAIN;
         DRAIN:   if (dmem_resp) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign acc_mask = byte_mask(e_type[hidx][1:0], e_addr[hidx][1:0]);

   always_comb begin
      dmem_addr  = '0;
      dmem_rmask = '0;
      dmem_wmask = '0;
      dmem_wdata = '0;
      if (state == REQ) begin
         dmem_addr = {e_addr[hidx][31:2], 2'b00};
         if (e_str[hidx]) begin
            dmem_wmask = acc_mask;
            dmem_wdata = e_sval[hidx] << {e_addr[hidx][1:0], 3'b000};
         end else begin
            dmem_rmask = acc_mask;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         head        <= '0;
         tail        <= '0;
         alloc       <= '0;
         addr_rdy    <= '0;
         deq_done    <= 1'b0;
         deq_ld_data <= '0;
         deq_rd      <= '0;
         deq_pd      <= '0;
         deq_rob_idx <= '0;
      end else begin
         state    <= state_nxt;
         deq_done <= do_cmpl;
         if (flush) begin
            alloc    <= '0;
            addr_rdy <= '0;
            tail     <= head;
         end else begin
            if (do_fill) addr_rdy[lsq_idx] <= 1'b1;
            if (do_disp) begin
               alloc[tidx]    <= 1'b1;
               addr_rdy[tidx] <= 1'b0;
               tail           <= tail + PTR_W'(1);
            end
            if (do_cmpl) begin
               alloc[hidx]    <= 1'b0;
               addr_rdy[hidx] <= 1'b0;
               head           <= head + PTR_W'(1);
            end
         end
         if (do_cmpl) begin
            deq_ld_data <= e_str[hidx] ? '0 : load_ext(dmem_rdata, e_addr[hidx][1:0], e_type[hidx]);
            deq_rd      <= e_str[hidx] ? '0 : e_rd[hidx];
            deq_pd      <= e_str[hidx] ? '0 : e_pd[hidx];
            deq_rob_idx <= e_rob[hidx];
         end
      end
   end

   // Entry payload carries no reset; alloc/addr_rdy qualify every use of it.
   always_ff @(posedge clk) begin
      if (do_fill) begin
         e_addr[lsq_idx] <= addr;
         e_type[lsq_idx] <= ld_str_type;
         e_rob[lsq_idx]  <= rob_idx;
         e_rd[lsq_idx]   <= rd;
         e_pd[lsq_idx]   <= pd;
         e_sval[lsq_idx] <= str_val;
         e_str[lsq_idx]  <= is_str;
      end
   end

`ifdef LSQ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ld_cnt   <= '0;
         perf_st_cnt   <= '0;
         perf_full_cyc <= '0;
      end else begin
         if (do_cmpl && !e_str[hidx]) perf_ld_cnt <= perf_ld_cnt + 32'd1;
         if (do_cmpl && e_str[hidx])  perf_st_cnt <= perf_st_cnt + 32'd1;
         if (full && disp_valid)      perf_full_cyc <= perf_full_cyc + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lsq_fifo.sv
// Bench for lsq_fifo: directed scenarios plus a queue-level reference model checked every cycle.
module tb_lsq_fifo;
   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst, flush, disp_valid, valid, is_str, dmem_resp;
   logic        disp_ready, deq_done;
   logic [2:0]  disp_lsq_idx, lsq_idx, ld_str_type;
   logic [31:0] addr, str_val, dmem_addr, dmem_wdata, dmem_rdata, deq_ld_data;
   logic [4:0]  rob_idx, rd, rob_head_idx, deq_rd, deq_rob_idx;
   logic [5:0]  pd, deq_pd;
   logic [3:0]  dmem_rmask, dmem_wmask;

   always #5 clk = ~clk;

   lsq_fifo #(.LSQ_DEPTH(D), .ROB_IDX_W(5), .PREG_W(6)) dut (
      .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_lsq_idx(disp_lsq_idx), .valid(valid), .addr(addr), .ld_str_type(ld_str_type),
      .lsq_idx(lsq_idx), .rob_idx(rob_idx), .rd(rd), .pd(pd), .str_val(str_val), .is_str(is_str),
      .rob_head_idx(rob_head_idx), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
      .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_resp(dmem_resp), .deq_done(deq_done), .deq_ld_data(deq_ld_data), .deq_rd(deq_rd),
      .deq_pd(deq_pd), .deq_rob_idx(deq_rob_idx));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: program-ordered queue of entries, head slot number, request bookkeeping.
   typedef struct {
      bit          filled;
      logic [31:0] addr;
      logic [2:0]  f3;
      logic [4:0]  rob;
      logic [4:0]  rd;
      logic [5:0]  pd;
      logic [31:0] sval;
      bit          is_str;
   } ent_t;

   ent_t        q[$];
   int          mhead = 0;
   bit          outstanding = 0, draining = 0, exp_req = 0, req_prev = 0, exp_done = 0, started = 0;
   logic [31:0] x_data;
   logic [4:0]  x_rob, x_rd;
   logic [5:0]  x_pd;

   function automatic logic [3:0] m_mask(input ent_t e);
      int n;
      n = (e.f3[1:0] == 2'd0) ? 1 : (e.f3[1:0] == 2'd1) ? 2 : 4;
      return 4'(((1 << n) - 1) << int'(e.addr[1:0]));
   endfunction

   function automatic logic [31:0] m_load(input ent_t e, input logic [31:0] rdata);
      logic [31:0] s;
      byte         b;
      shortint     h;
      s = rdata >> (8 * int'(e.addr[1:0]));
      b = s[7:0];
      h = s[15:0];
      case (e.f3)
         3'd0:    return 32'(int'(b));
         3'd1:    return 32'(int'(h));
         3'd4:    return s & 32'hFF;
         3'd5:    return s & 32'hFFFF;
         default: return s;
      endcase
   endfunction

   initial begin : model
      bit   idle, elig;
      int   off;
      ent_t e;
      forever begin
         @(posedge clk);
         started  = 1;
         req_prev = exp_req;
         exp_req  = 0;
         exp_done = 0;
         if (rst) begin
            q.delete();
            mhead = 0;
            outstanding = 0;
            draining = 0;
         end else begin
            idle = !outstanding && !draining;
            elig = (q.size() > 0) && q[0].filled && (!q[0].is_str || q[0].rob == rob_head_idx);
            if (draining && dmem_resp) draining = 0;
            if (outstanding && !req_prev && dmem_resp) begin
               outstanding = 0;
               if (!flush) begin
                  e        = q.pop_front();
                  mhead    = (mhead + 1) % D;
                  exp_done = 1;
                  x_rob    = e.rob;
                  x_rd     = e.is_str ? 5'd0 : e.rd;
                  x_pd     = e.is_str ? 6'd0 : e.pd;
                  x_data   = e.is_str ? 32'd0 : m_load(e, dmem_rdata);
               end
            end
            if (flush) begin
               q.delete();
               if (outstanding) begin
                  draining = 1;
                  outstanding = 0;
               end
            end else begin
               if (idle && elig) begin
                  exp_req = 1;
                  outstanding = 1;
               end
               if (valid) begin
                  off = (int'(lsq_idx) - mhead + D) % D;
                  if (off < q.size()) begin
                     e        = q[off];
                     e.filled = 1;
                     e.addr   = addr;
                     e.f3     = ld_str_type;
                     e.rob    = rob_idx;
                     e.rd     = rd;
                     e.pd     = pd;
                     e.sval   = str_val;
                     e.is_str = is_str;
                     q[off]   = e;
                  end
               end
               if (disp_valid && q.size() < D) begin
                  e = '{default: 0};
                  q.push_back(e);
               end
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (started) begin
            chk("disp_ready", 32'(disp_ready), 32'(q.size() != D));
            chk("disp_lsq_idx", 32'(disp_lsq_idx), 32'((mhead + q.size()) % D));
            chk("req_present", 32'((dmem_rmask | dmem_wmask) != 4'd0), 32'(exp_req));
            if (exp_req && q.size() > 0) begin
               chk("rmask", 32'(dmem_rmask), 32'(q[0].is_str ? 4'd0 : m_mask(q[0])));
               chk("wmask", 32'(dmem_wmask), 32'(q[0].is_str ? m_mask(q[0]) : 4'd0));
               chk("dmem_addr", dmem_addr, q[0].addr & 32'hFFFF_FFFC);
               if (q[0].is_str)
                  chk("wdata", dmem_wdata, q[0].sval << (8 * int'(q[0].addr[1:0])));
            end
            chk("deq_done", 32'(deq_done), 32'(exp_done));
            if (exp_done && deq_done) begin
               chk("deq_ld_data", deq_ld_data, x_data);
               chk("deq_rd", 32'(deq_rd), 32'(x_rd));
               chk("deq_pd", 32'(deq_pd), 32'(x_pd));
               chk("deq_rob_idx", 32'(deq_rob_idx), 32'(x_rob));
            end
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic dispatch(input int n);
      disp_valid = 1'b1;
      repeat (n) cyc();
      disp_valid = 1'b0;
   endtask

   task automatic fill(input int idx, input logic [31:0] a, input logic [2:0] f, input logic [4:0] rb,
                       input logic [4:0] r, input logic [5:0] p, input logic [31:0] sv, input logic st);
      valid = 1'b1;
      lsq_idx = 3'(idx);
      addr = a;
      ld_str_type = f;
      rob_idx = rb;
      rd = r;
      pd = p;
      str_val = sv;
      is_str = st;
      cyc();
      valid = 1'b0;
   endtask

   task automatic wait_req(output logic [3:0] rm, output logic [3:0] wm,
                           output logic [31:0] a, output logic [31:0] wd);
      int n = 0;
      while ((dmem_rmask | dmem_wmask) == 4'd0 && n < 20) begin
         cyc();
         n++;
      end
      chk("req_timeout", 32'(n < 20), 32'd1);
      rm = dmem_rmask;
      wm = dmem_wmask;
      a  = dmem_addr;
      wd = dmem_wdata;
   endtask

   task automatic respond(input logic [31:0] data);
      cyc();
      dmem_rdata = data;
      dmem_resp = 1'b1;
      cyc();
      dmem_resp = 1'b0;
   endtask

   logic [3:0]  rm, wm;
   logic [31:0] ra, rw;

   initial begin : stim
      rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; valid = 1'b0; is_str = 1'b0; dmem_resp = 1'b0;
      lsq_idx = '0; ld_str_type = '0; addr = '0; str_val = '0; dmem_rdata = '0;
      rob_idx = '0; rd = '0; pd = '0; rob_head_idx = '0;
      cyc();
      cyc();
      rst = 1'b0;
      chk("rst_disp_ready", 32'(disp_ready), 32'd1);
      chk("rst_disp_idx", 32'(disp_lsq_idx), 32'd0);
      chk("rst_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
      chk("rst_deq", 32'({deq_done, deq_rd, deq_pd, deq_rob_idx}), 32'd0);
      chk("rst_deq_data", deq_ld_data, 32'd0);

      // lw 0x1004
      dispatch(1);
      fill(0, 32'h1004, 3'b010, 5'd3, 5'd7, 6'd9, 32'd0, 1'b0);
      wait_req(rm, wm, ra, rw);
      chk("lw_rmask", 32'(rm), 32'h0000_000F);
      chk("lw_wmask", 32'(wm), 32'd0);
      chk("lw_addr", ra, 32'h1004);
      respond(32'hDEADBEEF);
      chk("lw_done", 32'(deq_done), 32'd1);
      chk("lw_data", deq_ld_data, 32'hDEADBEEF);
      chk("lw_pd", 32'(deq_pd), 32'd9);
      chk("lw_rd", 32'(deq_rd), 32'd7);
      cyc();
      chk("lw_done_pulse", 32'(deq_done), 32'd0);

      // lb / lbu at 0x1003, lh at 0x1002
      dispatch(1);
      fill(1, 32'h1003, 3'b000, 5'd4, 5'd1, 6'd2, 32'd0, 1'b0);
      wait_req(rm, wm, ra, rw);
      chk("lb_rmask", 32'(rm), 32'h0000_0008);
      respond(32'h80FFFFFF);
      chk("lb_data", deq_ld_data, 32'hFFFFFF80);
      dispatch(1);
      fill(2, 32'h1003, 3'b100, 5'd5, 5'd1, 6'd2, 32'd0, 1'b0);
      wait_req(rm, wm, ra, rw);
      respond(32'h80FFFFFF);
      chk("lbu_data", deq_ld_data, 32'h00000080);
      dispatch(1);
      fill(3, 32'h1002, 3'b001, 5'd6, 5'd1, 6'd2, 32'd0, 1'b0);
      wait_req(rm, wm, ra, rw);
      chk("lh_rmask", 32'(rm), 32'h0000_000C);
      respond(32'h8001_1234);
      chk("lh_data", deq_ld_data, 32'hFFFF8001);

      // sh at 0x2002, held until the ROB head matches
      chk("sh_idx", 32'(disp_lsq_idx), 32'd4);
      dispatch(1);
      rob_head_idx = 5'd0;
      fill(4, 32'h2002, 3'b001, 5'd5, 5'd3, 6'd12, 32'h1234, 1'b1);
      repeat (5) begin
         cyc();
         chk("sh_held", 32'(dmem_rmask | dmem_wmask), 32'd0);
      end
      rob_head_idx = 5'd5;
      wait_req(rm, wm, ra, rw);
      chk("sh_wmask", 32'(wm), 32'h0000_000C);
      chk("sh_rmask", 32'(rm), 32'd0);
      chk("sh_wdata", rw, 32'h12340000);
      chk("sh_addr", ra, 32'h2000);
      respond(32'd0);
      chk("sh_done", 32'(deq_done), 32'd1);
      chk("sh_pd", 32'(deq_pd), 32'd0);
      chk("sh_rob", 32'(deq_rob_idx), 32'd5);
      rob_head_idx = 5'd0;

      // fill all eight entries, ninth dispatch ignored
      do_reset();
      disp_valid = 1'b1;
      for (int i = 0; i < D; i++) begin
         chk("full_idx", 32'(disp_lsq_idx), 32'(i));
         cyc();
      end
      chk("full_ready", 32'(disp_ready), 32'd0);
      cyc();
      disp_valid = 1'b0;
      chk("full_ignored_ready", 32'(disp_ready), 32'd0);
      chk("full_ignored_idx", 32'(disp_lsq_idx), 32'd0);
      fill(0, 32'h40, 3'b010, 5'd1, 5'd1, 6'd1, 32'd0, 1'b0);
      wait_req(rm, wm, ra, rw);
      respond(32'h55);
      chk("wrap_done", 32'(deq_done), 32'd1);
      chk("wrap_ready", 32'(disp_ready), 32'd1);
      chk("wrap_idx", 32'(disp_lsq_idx), 32'd0);

      // flush during WAIT with three entries queued
      do_reset();
      dispatch(3);
      fill(2, 32'h108, 3'b010, 5'd3, 5'd2, 6'd22, 32'd0, 1'b0);
      fill(1, 32'h104, 3'b010, 5'd2, 5'd2, 6'd21, 32'd0, 1'b0);
      fill(0, 32'h100, 3'b010, 5'd1, 5'd2, 6'd20, 32'd0, 1'b0);
      wait_req(rm, wm, ra, rw);
      chk("fl_addr", ra, 32'h100);
      cyc();
      flush = 1'b1;
      disp_valid = 1'b1;
      valid = 1'b1;
      lsq_idx = 3'd1;
      cyc();
      flush = 1'b0;
      disp_valid = 1'b0;
      valid = 1'b0;
      cyc();
      chk("fl_no_done_a", 32'(deq_done), 32'd0);
      dmem_rdata = 32'h77;
      dmem_resp = 1'b1;
      cyc();
      dmem_resp = 1'b0;
      chk("fl_no_done_b", 32'(deq_done), 32'd0);
      cyc();
      chk("fl_no_done_c", 32'(deq_done), 32'd0);
      chk("fl_empty", 32'(disp_ready), 32'd1);
      chk("fl_tail_eq_head", 32'(disp_lsq_idx), 32'd0);
      dispatch(1);
      fill(0, 32'h200, 3'b010, 5'd9, 5'd2, 6'd33, 32'd0, 1'b0);
      wait_req(rm, wm, ra, rw);
      respond(32'hA5A5A5A5);
      chk("fl_after_pd", 32'(deq_pd), 32'd33);
      chk("fl_after_data", deq_ld_data, 32'hA5A5A5A5);

      // out-of-order fill: idx1 before idx0
      do_reset();
      dispatch(2);
      fill(1, 32'h3000, 3'b010, 5'd2, 5'd4, 6'd11, 32'd0, 1'b0);
      repeat (4) begin
         cyc();
         chk("ooo_held", 32'(dmem_rmask | dmem_wmask), 32'd0);
      end
      fill(0, 32'h3008, 3'b010, 5'd1, 5'd3, 6'd10, 32'd0, 1'b0);
      wait_req(rm, wm, ra, rw);
      chk("ooo_first_addr", ra, 32'h3008);
      respond(32'h11111111);
      chk("ooo_first_pd", 32'(deq_pd), 32'd10);
      wait_req(rm, wm, ra, rw);
      chk("ooo_second_addr", ra, 32'h3000);
      respond(32'h22222222);
      chk("ooo_second_pd", 32'(deq_pd), 32'd11);
      chk("ooo_second_data", deq_ld_data, 32'h22222222);

      repeat (3) cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
